// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring integer divider for the DIV/REM execution unit.
//   Produces quotient and remainder at a fixed latency of N+1 edges after
//   acceptance. Divide-by-zero and signed MIN/-1 are resolved in one edge.
//   Signed division truncates toward zero, and the remainder takes the sign of
//   the dividend.
//
// Ports
//   clk            clock, rising edge
//   rstn           asynchronous active-low reset
//   req_i          start request, sampled only while idle
//   signed_mode_i  1 = two's-complement operands, 0 = unsigned
//   dividend_i     numerator   (N bits)
//   divisor_i      denominator (N bits)
//   busy_o         high while a division is in flight
//   ready_o        one-cycle pulse: q_o/r_o/exception_o/overflow_o are valid
//   q_o, r_o       quotient / remainder of the last completed division
//   exception_o    last result was a divide-by-zero
//   overflow_o     last result was a signed overflow (MIN / -1)
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter  int N     = 16,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_i,
  input  logic         signed_mode_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [N-1:0] q_o,
  output logic [N-1:0] r_o,
  output logic         exception_o,
  output logic         overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N:0]       rem_q,   rem_d;    // partial remainder, one guard bit
  logic [N-1:0]     quo_q,   quo_d;    // dividend bits shift out, quotient bits shift in
  logic [N-1:0]     dvs_q,   dvs_d;    // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [N-1:0]     q_q,     q_d;
  logic [N-1:0]     r_q,     r_d;
  logic             exc_q,   exc_d;
  logic             ovf_q,   ovf_d;
  logic             ready_q, ready_d;

  // Operand sign and magnitude. The magnitude of MIN is 2^(N-1), which still
  // fits in N unsigned bits, so no extra width is needed here.
  logic         dividend_neg, divisor_neg;
  logic [N-1:0] dividend_mag, divisor_mag;

  assign dividend_neg = signed_mode_i & dividend_i[N-1];
  assign divisor_neg  = signed_mode_i & divisor_i[N-1];
  assign dividend_mag = dividend_neg ? -dividend_i : dividend_i;
  assign divisor_mag  = divisor_neg  ? -divisor_i  : divisor_i;

  logic is_div_zero, is_sgn_ovf;

  assign is_div_zero = (divisor_i == '0);
  assign is_sgn_ovf  = signed_mode_i && (dividend_i == MIN_VAL) && (divisor_i == '1);

  // One restoring step. The shifted remainder is below 2*divisor < 2^(N+1),
  // so computing the trial difference one bit wider than the remainder makes
  // its MSB a reliable borrow/sign flag.
  logic [N+1:0] rem_shift;
  logic [N+1:0] rem_trial;
  logic         trial_neg;

  assign rem_shift = {rem_q, quo_q[N-1]};
  assign rem_trial = rem_shift - {2'b00, dvs_q};
  assign trial_neg = rem_trial[N+1];

  logic last_step;
  assign last_step = (cnt_q == CNT_W'(N - 1));

  // NOTE: every variable written in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    q_d     = q_q;
    r_d     = r_q;
    exc_d   = exc_q;
    ovf_d   = ovf_q;
    ready_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (is_div_zero) begin
            q_d     = '1;
            r_d     = dividend_i;
            exc_d   = 1'b1;
            ovf_d   = 1'b0;
            ready_d = 1'b1;
          end else if (is_sgn_ovf) begin
            q_d     = dividend_i;
            r_d     = '0;
            exc_d   = 1'b0;
            ovf_d   = 1'b1;
            ready_d = 1'b1;
          end else begin
            quo_d   = dividend_mag;
            dvs_d   = divisor_mag;
            q_neg_d = dividend_neg ^ divisor_neg;
            r_neg_d = dividend_neg;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (trial_neg) begin
          rem_d = rem_shift[N:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end else begin
          rem_d = rem_trial[N:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // The final remainder is below the divisor magnitude, so its low N
        // bits carry the whole value.
        q_d     = q_neg_q ? -quo_q : quo_q;
        r_d     = r_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
        exc_d   = 1'b0;
        ovf_d   = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      exc_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      exc_q   <= exc_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign ready_o     = ready_q;
  assign q_o         = q_q;
  assign r_o         = r_q;
  assign exception_o = exc_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (N=16): a table of directed vectors,
//   hand-written multi-cycle sequences (req while busy, reset abort), and
//   randomized operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int N       = 16;
  localparam int NORM_LAT = N + 1;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req;
  logic         signed_mode;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         ready;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         exception;
  logic         overflow;

  seq_divider #(.N(N)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_i         (req),
    .signed_mode_i (signed_mode),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .ready_o       (ready),
    .q_o           (q),
    .r_o           (r),
    .exception_o   (exception),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic void ref_div(input logic sm, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] eq, output logic [N-1:0] er,
                                  output logic ee, output logic eo, output int elat);
    int sa, sb, qi, ri;
    ee = 1'b0;
    eo = 1'b0;
    if (b == 0) begin
      eq = '1; er = a; ee = 1'b1; elat = 0;
    end else if (sm && a == 16'h8000 && b == 16'hFFFF) begin
      eq = a; er = '0; eo = 1'b1; elat = 0;
    end else if (sm) begin
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      eq = qi[N-1:0];
      er = ri[N-1:0];
      elat = NORM_LAT;
    end else begin
      eq = a / b;
      er = a % b;
      elat = NORM_LAT;
    end
  endfunction

  // Present one request, then count edges until ready (bounded).
  task automatic run_div(input logic sm, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int edges, output int busy_cyc);
    @(negedge clk);
    req = 1'b1; signed_mode = sm; dividend = a; divisor = b;
    @(posedge clk); #1;
    // Inputs only need to be stable at the accepting edge.
    req = 1'b0; signed_mode = 1'($urandom); dividend = 16'($urandom); divisor = 16'($urandom);
    edges = 0;
    busy_cyc = 0;
    while (!ready && edges < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic apply_and_check(input string name, input logic sm, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic [N-1:0] eq,
                                 input logic [N-1:0] er, input logic ee, input logic eo,
                                 input int elat);
    int edges, busy_cyc;
    run_div(sm, a, b, edges, busy_cyc);
    check({name, ".latency"}, edges, elat);
    check({name, ".busy_cycles"}, busy_cyc, elat);
    check({name, ".q"}, q, eq);
    check({name, ".r"}, r, er);
    check({name, ".exception"}, exception, ee);
    check({name, ".overflow"}, overflow, eo);
    @(posedge clk); #1;
    check({name, ".ready_pulse"}, ready, 1'b0);
    check({name, ".q_hold"}, q, eq);
  endtask

  typedef struct {
    logic         sm;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ee;
    logic         eo;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] eq, er;
    logic         ee, eo;
    int           elat;
    int           pulses, first_pulse, hold_bad, edges, busy_cyc;
    logic [N-1:0] pulse_q, pulse_r;

    vecs[0]  = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, NORM_LAT};
    vecs[1]  = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, NORM_LAT};
    vecs[2]  = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, NORM_LAT};
    vecs[3]  = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0};
    vecs[4]  = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0};
    vecs[5]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 0};
    vecs[6]  = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, NORM_LAT};
    vecs[7]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, NORM_LAT};
    vecs[8]  = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, NORM_LAT};
    vecs[9]  = '{1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 1'b0, NORM_LAT};
    vecs[10] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, NORM_LAT};
    vecs[11] = '{1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 1'b0, NORM_LAT};

    rstn = 1'b0; req = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 1'b0);
    check("reset.ready", ready, 1'b0);
    check("reset.q", q, 16'h0);
    check("reset.r", r, 16'h0);
    check("reset.exception", exception, 1'b0);
    check("reset.overflow", overflow, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("post_reset.busy", busy, 1'b0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      apply_and_check($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b,
                      vecs[i].eq, vecs[i].er, vecs[i].ee, vecs[i].eo, vecs[i].lat);
    end

    // req with 5/1 while busy must be ignored: one pulse only, and the old
    // result (0x0FFF / 0x000F from the last vector) holds until 0xFFFF/0xFFFF completes.
    @(negedge clk);
    req = 1'b1; signed_mode = 1'b0; dividend = 16'hFFFF; divisor = 16'hFFFF;
    @(posedge clk); #1;
    dividend = 16'd5; divisor = 16'd1;
    pulses = 0; first_pulse = -1; hold_bad = 0; pulse_q = '0; pulse_r = '0;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk); #1;
      if (i == 14) req = 1'b0;
      if (ready) begin
        pulses++;
        if (first_pulse < 0) begin
          first_pulse = i; pulse_q = q; pulse_r = r;
        end
      end else if (first_pulse < 0 && (q !== 16'h0FFF || r !== 16'h000F)) begin
        hold_bad++;
      end
    end
    check("busy_ignore.pulses", pulses, 1);
    check("busy_ignore.latency", first_pulse, NORM_LAT);
    check("busy_ignore.q", pulse_q, 16'h0001);
    check("busy_ignore.r", pulse_r, 16'h0000);
    check("busy_ignore.hold_violations", hold_bad, 0);
    check("busy_ignore.final_q", q, 16'h0001);

    // Reset mid-operation: put nonzero values on the outputs first.
    apply_and_check("pre_abort", 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0);
    @(negedge clk);
    req = 1'b1; signed_mode = 1'b0; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("abort.busy", busy, 1'b0);
    check("abort.ready", ready, 1'b0);
    check("abort.q", q, 16'h0);
    check("abort.r", r, 16'h0);
    check("abort.exception", exception, 1'b0);
    check("abort.overflow", overflow, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ready || busy) pulses++;
    end
    check("abort.no_activity", pulses, 0);
    apply_and_check("after_abort", 1'b0, 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, NORM_LAT);

    // Randomized operations against the reference model.
    for (int i = 0; i < 250; i++) begin
      logic         sm;
      logic [N-1:0] a, b;
      int           kind;
      sm   = 1'($urandom);
      a    = 16'($urandom);
      b    = 16'($urandom);
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: b = '0;
        1: begin sm = 1'b1; a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(1, 15));
        3: a = 16'h8000;
        4: b = 16'hFFFF;
        default: ;
      endcase
      ref_div(sm, a, b, eq, er, ee, eo, elat);
      apply_and_check($sformatf("rand%0d", i), sm, a, b, eq, er, ee, eo, elat);
    end

    // Fast path immediately followed by a normal division.
    run_div(1'b1, 16'h8000, 16'hFFFF, edges, busy_cyc);
    check("b2b.fast_latency", edges, 0);
    run_div(1'b1, 16'hFF9C, 16'h0007, edges, busy_cyc);
    check("b2b.norm_latency", edges, NORM_LAT);
    check("b2b.q", q, 16'hFFF2);
    check("b2b.r", r, 16'hFFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
